// File: rtl/sys_ctrl_if.sv
// Bus bundle between sys_ctrl and its UART, register-file, ALU and TX neighbours.
// The master modport is the sequencer side and the slave modport is the environment side.
interface sys_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic [DATA_W-1:0]   i_rx_data;
  logic                i_rx_valid;
  logic                o_rf_wr_en;
  logic                o_rf_rd_en;
  logic [ADDR_W-1:0]   o_rf_addr;
  logic [DATA_W-1:0]   o_rf_wr_data;
  logic [DATA_W-1:0]   i_rf_rd_data;
  logic                i_rf_rd_valid;
  logic                o_alu_en;
  logic [FUN_W-1:0]    o_alu_fun;
  logic                o_alu_gate_en;
  logic [2*DATA_W-1:0] i_alu_out;
  logic                i_alu_valid;
  logic [DATA_W-1:0]   o_tx_data;
  logic                o_tx_valid;
  logic                i_tx_busy;
  logic                o_cmd_err;

  modport master (
    input  i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
           i_alu_out, i_alu_valid, i_tx_busy,
    output o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wr_data, o_alu_en,
           o_alu_fun, o_alu_gate_en, o_tx_data, o_tx_valid, o_cmd_err
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
           i_alu_out, i_alu_valid, i_tx_busy,
    input  o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wr_data, o_alu_en,
           o_alu_fun, o_alu_gate_en, o_tx_data, o_tx_valid, o_cmd_err
  );
endinterface

// File: rtl/sys_ctrl.sv
// Byte-command sequencer: parses RX frames into register-file / ALU operations and returns results on TX.
// Optional feature: define CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module sys_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sys_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A, S_OP_B,
    S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_OP  = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_ALU = DATA_W'(8'hDD);

  state_t              r_state, w_next;
  logic                r_rf_wr_en, r_rf_rd_en, r_alu_en, r_alu_kick, r_alu_gate;
  logic                r_tx_valid, r_cmd_err, r_single;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic [DATA_W-1:0]   r_rf_wr_data, r_tx_data, r_res_hi;
  logic [FUN_W-1:0]    r_alu_fun;

  logic                w_rf_wr_en, w_rf_rd_en, w_alu_kick, w_alu_gate;
  logic                w_tx_valid, w_single, w_err, w_timeout;
  logic [ADDR_W-1:0]   w_rf_addr;
  logic [DATA_W-1:0]   w_rf_wr_data, w_tx_data, w_res_hi;
  logic [FUN_W-1:0]    w_alu_fun;
  logic                w_rx, w_tx_acc, w_in_frame;

  assign w_rx       = bus.i_rx_valid;
  assign w_tx_acc   = r_tx_valid & ~bus.i_tx_busy;
  assign w_in_frame = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                      (r_state == S_RD_ADDR) || (r_state == S_OP_A)    ||
                      (r_state == S_OP_B)    || (r_state == S_ALU_FUN);

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_to_cnt;

  // Counts idle cycles inside a partially received frame.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_rx || !w_in_frame) r_to_cnt <= '0;
    else                              r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = w_in_frame && !w_rx && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0) ^ w_in_frame;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: if (w_rx) begin
        if      (bus.i_rx_data == CMD_WR)  w_next = S_WR_ADDR;
        else if (bus.i_rx_data == CMD_RD)  w_next = S_RD_ADDR;
        else if (bus.i_rx_data == CMD_OP)  w_next = S_OP_A;
        else if (bus.i_rx_data == CMD_ALU) w_next = S_ALU_FUN;
        else                               w_err  = 1'b1;
      end
      S_WR_ADDR:  if (w_rx) w_next = S_WR_DATA;
      S_WR_DATA:  if (w_rx) w_next = S_IDLE;
      S_RD_ADDR:  if (w_rx) w_next = S_RD_WAIT;
      S_OP_A:     if (w_rx) w_next = S_OP_B;
      S_OP_B:     if (w_rx) w_next = S_ALU_FUN;
      S_ALU_FUN:  if (w_rx) w_next = S_ALU_WAIT;
      S_RD_WAIT: begin
        w_err = w_rx;
        if (bus.i_rf_rd_valid) w_next = S_TX_LO;
      end
      S_ALU_WAIT: begin
        w_err = w_rx;
        if (bus.i_alu_valid) w_next = S_TX_LO;
      end
      S_TX_LO: begin
        w_err = w_rx;
        if (w_tx_acc) w_next = r_single ? S_IDLE : S_TX_HI;
      end
      S_TX_HI: begin
        w_err = w_rx;
        if (w_tx_acc) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_next = S_IDLE;
      w_err  = 1'b1;
    end
  end

  // Next values of the registered outputs; every strobe is a single registered cycle.
  always_comb begin
    w_rf_wr_en   = 1'b0;
    w_rf_rd_en   = 1'b0;
    w_rf_addr    = r_rf_addr;
    w_rf_wr_data = r_rf_wr_data;
    w_alu_kick   = 1'b0;
    w_alu_gate   = r_alu_gate;
    w_alu_fun    = r_alu_fun;
    w_tx_valid   = r_tx_valid;
    w_tx_data    = r_tx_data;
    w_res_hi     = r_res_hi;
    w_single     = r_single;
    case (r_state)
      S_WR_ADDR: if (w_rx) w_rf_addr = bus.i_rx_data[ADDR_W-1:0];
      S_WR_DATA: if (w_rx) begin
        w_rf_wr_en   = 1'b1;
        w_rf_wr_data = bus.i_rx_data;
      end
      S_RD_ADDR: if (w_rx) begin
        w_rf_rd_en = 1'b1;
        w_rf_addr  = bus.i_rx_data[ADDR_W-1:0];
        w_single   = 1'b1;
      end
      S_RD_WAIT: if (bus.i_rf_rd_valid) begin
        w_tx_data  = bus.i_rf_rd_data;
        w_tx_valid = 1'b1;
      end
      S_OP_A, S_OP_B: if (w_rx) begin
        w_rf_wr_en   = 1'b1;
        w_rf_addr    = (r_state == S_OP_A) ? ADDR_W'(0) : ADDR_W'(1);
        w_rf_wr_data = bus.i_rx_data;
      end
      S_ALU_FUN: if (w_rx) begin
        w_alu_fun  = bus.i_rx_data[FUN_W-1:0];
        w_alu_gate = 1'b1;
        w_alu_kick = 1'b1;
        w_single   = 1'b0;
      end
      S_ALU_WAIT: if (bus.i_alu_valid) begin
        w_alu_gate = 1'b0;
        w_tx_data  = bus.i_alu_out[DATA_W-1:0];
        w_res_hi   = bus.i_alu_out[2*DATA_W-1:DATA_W];
        w_tx_valid = 1'b1;
      end
      S_TX_LO: if (w_tx_acc) begin
        if (r_single) w_tx_valid = 1'b0;
        else          w_tx_data  = r_res_hi;
      end
      S_TX_HI: if (w_tx_acc) begin
        w_tx_valid = 1'b0;
        w_alu_fun  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_wr_data <= '0;
      r_alu_kick   <= 1'b0;
      r_alu_en     <= 1'b0;
      r_alu_gate   <= 1'b0;
      r_alu_fun    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_res_hi     <= '0;
      r_single     <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_rf_wr_en   <= w_rf_wr_en;
      r_rf_rd_en   <= w_rf_rd_en;
      r_rf_addr    <= w_rf_addr;
      r_rf_wr_data <= w_rf_wr_data;
      r_alu_kick   <= w_alu_kick;
      r_alu_en     <= r_alu_kick;
      r_alu_gate   <= w_alu_gate;
      r_alu_fun    <= w_alu_fun;
      r_tx_valid   <= w_tx_valid;
      r_tx_data    <= w_tx_data;
      r_res_hi     <= w_res_hi;
      r_single     <= w_single;
      r_cmd_err    <= w_err;
    end
  end

  assign bus.o_rf_wr_en    = r_rf_wr_en;
  assign bus.o_rf_rd_en    = r_rf_rd_en;
  assign bus.o_rf_addr     = r_rf_addr;
  assign bus.o_rf_wr_data  = r_rf_wr_data;
  assign bus.o_alu_en      = r_alu_en;
  assign bus.o_alu_fun     = r_alu_fun;
  assign bus.o_alu_gate_en = r_alu_gate;
  assign bus.o_tx_data     = r_tx_data;
  assign bus.o_tx_valid    = r_tx_valid;
  assign bus.o_cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: write, read, ALU, TX back-pressure, error and timeout frames.
module tb_sys_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FUN_W  = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W)) bus ();

  sys_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [7:0] tx_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.o_tx_valid && !bus.i_tx_busy) begin
        tx_q.push_back(bus.o_tx_data);
        tx_cnt++;
      end
      if (bus.o_rf_wr_en) wr_cnt++;
      if (bus.o_rf_rd_en) rd_cnt++;
      if (bus.o_cmd_err)  err_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_rx_data = '0; bus.i_rx_valid = 0; bus.i_rf_rd_data = '0; bus.i_rf_rd_valid = 0;
    bus.i_alu_out = '0; bus.i_alu_valid = 0; bus.i_tx_busy = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_rd_en, bus.o_alu_en, bus.o_alu_gate_en,
         bus.o_tx_valid, bus.o_cmd_err} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b, want 000000", {bus.o_rf_wr_en, bus.o_rf_rd_en,
               bus.o_alu_en, bus.o_alu_gate_en, bus.o_tx_valid, bus.o_cmd_err});
    end
    n_checks++;
    if ({bus.o_rf_addr, bus.o_rf_wr_data, bus.o_alu_fun, bus.o_tx_data} !== 24'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h, want 000000",
               {bus.o_rf_addr, bus.o_rf_wr_data, bus.o_alu_fun, bus.o_tx_data});
    end
    tick(2);
  endtask

  task automatic test_write();
    int tx0 = tx_cnt, wr0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h05);
    n_checks++;
    if (bus.o_rf_wr_en !== 1'b0) begin
      n_errors++; $display("FAIL wr_early: wr_en=%b, want 0", bus.o_rf_wr_en);
    end
    send_byte(8'h3C);
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data} !== {1'b1, 4'h5, 8'h3C}) begin
      n_errors++;
      $display("FAIL wr_pulse: en=%b addr=%h data=%h, want 1/5/3c",
               bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
    end
    tick();
    n_checks++;
    if (bus.o_rf_wr_en !== 1'b0) begin
      n_errors++; $display("FAIL wr_width: wr_en=%b one cycle later, want 0", bus.o_rf_wr_en);
    end
    tick(5);
    n_checks++;
    if (wr_cnt - wr0 != 1 || tx_cnt != tx0) begin
      n_errors++;
      $display("FAIL wr_counts: wr=%0d tx=%0d, want 1/0", wr_cnt - wr0, tx_cnt - tx0);
    end
  endtask

  task automatic test_addr_mask();
    send_byte(8'hAA);
    send_byte(8'hF7);
    send_byte(8'h99);
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data} !== {1'b1, 4'h7, 8'h99}) begin
      n_errors++;
      $display("FAIL addr_mask: en=%b addr=%h data=%h, want 1/7/99",
               bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
    end
    tick(2);
  endtask

  task automatic test_read();
    int tx0 = tx_cnt;
    bit done = 0;
    send_byte(8'hBB);
    send_byte(8'h05);
    n_checks++;
    if ({bus.o_rf_rd_en, bus.o_rf_addr} !== {1'b1, 4'h5}) begin
      n_errors++;
      $display("FAIL rd_pulse: en=%b addr=%h, want 1/5", bus.o_rf_rd_en, bus.o_rf_addr);
    end
    tick(3);
    bus.i_rf_rd_data = 8'h3C; bus.i_rf_rd_valid = 1'b1;
    tick();
    bus.i_rf_rd_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (tx_cnt - tx0 >= 1) done = 1; else tick();
    end
    tick(5);
    n_checks++;
    if (tx_cnt - tx0 != 1 || tx_q.size() == 0) begin
      n_errors++; $display("FAIL rd_tx_count: got %0d bytes, want 1", tx_cnt - tx0);
    end else if (tx_q[$] !== 8'h3C) begin
      n_errors++; $display("FAIL rd_tx_byte: got %h, want 3c", tx_q[$]);
    end
  endtask

  task automatic test_alu_op();
    int tx0 = tx_cnt;
    bit done = 0;
    send_byte(8'hCC);
    send_byte(8'h10);
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data} !== {1'b1, 4'h0, 8'h10}) begin
      n_errors++;
      $display("FAIL op_a: en=%b addr=%h data=%h, want 1/0/10",
               bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
    end
    send_byte(8'h20);
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data} !== {1'b1, 4'h1, 8'h20}) begin
      n_errors++;
      $display("FAIL op_b: en=%b addr=%h data=%h, want 1/1/20",
               bus.o_rf_wr_en, bus.o_rf_addr, bus.o_rf_wr_data);
    end
    send_byte(8'hF1);
    n_checks++;
    if ({bus.o_alu_gate_en, bus.o_alu_en, bus.o_alu_fun} !== {1'b1, 1'b0, 4'h1}) begin
      n_errors++;
      $display("FAIL alu_gate: gate=%b en=%b fun=%h, want 1/0/1",
               bus.o_alu_gate_en, bus.o_alu_en, bus.o_alu_fun);
    end
    tick();
    n_checks++;
    if (bus.o_alu_en !== 1'b1) begin
      n_errors++; $display("FAIL alu_en: got %b, want 1", bus.o_alu_en);
    end
    tick();
    n_checks++;
    if (bus.o_alu_en !== 1'b0) begin
      n_errors++; $display("FAIL alu_en_width: got %b, want 0", bus.o_alu_en);
    end
    bus.i_alu_out = 16'h0030; bus.i_alu_valid = 1'b1;
    tick();
    bus.i_alu_valid = 1'b0;
    n_checks++;
    if ({bus.o_alu_gate_en, bus.o_tx_valid, bus.o_tx_data} !== {1'b0, 1'b1, 8'h30}) begin
      n_errors++;
      $display("FAIL alu_result: gate=%b txv=%b txd=%h, want 0/1/30",
               bus.o_alu_gate_en, bus.o_tx_valid, bus.o_tx_data);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      if (tx_cnt - tx0 >= 2) done = 1; else tick();
    end
    tick(4);
    n_checks++;
    if (tx_cnt - tx0 != 2 || tx_q.size() < 2) begin
      n_errors++; $display("FAIL alu_tx_count: got %0d bytes, want 2", tx_cnt - tx0);
    end else if ({tx_q[$-1], tx_q[$]} !== 16'h3000) begin
      n_errors++; $display("FAIL alu_tx_bytes: got %h %h, want 30 00", tx_q[$-1], tx_q[$]);
    end
    n_checks++;
    if ({bus.o_tx_valid, bus.o_alu_fun} !== 5'b0) begin
      n_errors++;
      $display("FAIL alu_done: txv=%b fun=%h, want 0/0", bus.o_tx_valid, bus.o_alu_fun);
    end
  endtask

  task automatic test_tx_busy();
    int tx0 = tx_cnt;
    bit done = 0;
    bus.i_tx_busy = 1'b1;
    send_byte(8'hDD);
    send_byte(8'h02);
    tick(2);
    bus.i_alu_out = 16'h1234; bus.i_alu_valid = 1'b1;
    tick();
    bus.i_alu_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({bus.o_tx_valid, bus.o_tx_data} !== {1'b1, 8'h34}) begin
        n_errors++;
        $display("FAIL busy_hold[%0d]: txv=%b txd=%h, want 1/34", i, bus.o_tx_valid, bus.o_tx_data);
      end
      tick();
    end
    n_checks++;
    if (tx_cnt != tx0) begin
      n_errors++; $display("FAIL busy_no_send: got %0d bytes, want 0", tx_cnt - tx0);
    end
    bus.i_tx_busy = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (tx_cnt - tx0 >= 2) done = 1; else tick();
    end
    tick(6);
    n_checks++;
    if (tx_cnt - tx0 != 2 || tx_q.size() < 2) begin
      n_errors++; $display("FAIL busy_tx_count: got %0d bytes, want 2", tx_cnt - tx0);
    end else if ({tx_q[$-1], tx_q[$]} !== 16'h3412) begin
      n_errors++; $display("FAIL busy_tx_bytes: got %h %h, want 34 12", tx_q[$-1], tx_q[$]);
    end
  endtask

  task automatic test_errors();
    int tx0 = tx_cnt, err0 = err_cnt;
    bit done = 0;
    send_byte(8'h55);
    n_checks++;
    if (bus.o_cmd_err !== 1'b1) begin
      n_errors++; $display("FAIL err_unknown: got %b, want 1", bus.o_cmd_err);
    end
    bus.i_alu_valid = 1'b1; bus.i_alu_out = 16'hEEEE;
    tick();
    bus.i_alu_valid = 1'b0;
    tick(3);
    n_checks++;
    if (tx_cnt != tx0 || bus.o_tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL stray_strobe: txv=%b bytes=%0d, want 0/0", bus.o_tx_valid, tx_cnt - tx0);
    end
    send_byte(8'hDD);
    send_byte(8'h03);
    tick(2);
    send_byte(8'h77);
    n_checks++;
    if (bus.o_cmd_err !== 1'b1) begin
      n_errors++; $display("FAIL err_drop: got %b, want 1", bus.o_cmd_err);
    end
    bus.i_alu_out = 16'h00AB; bus.i_alu_valid = 1'b1;
    tick();
    bus.i_alu_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (tx_cnt - tx0 >= 2) done = 1; else tick();
    end
    tick(4);
    n_checks++;
    if (tx_cnt - tx0 != 2 || tx_q.size() < 2) begin
      n_errors++; $display("FAIL err_tx_count: got %0d bytes, want 2", tx_cnt - tx0);
    end else if ({tx_q[$-1], tx_q[$]} !== 16'hAB00) begin
      n_errors++; $display("FAIL err_tx_bytes: got %h %h, want ab 00", tx_q[$-1], tx_q[$]);
    end
    n_checks++;
    if (err_cnt - err0 != 2) begin
      n_errors++; $display("FAIL err_count: got %0d pulses, want 2", err_cnt - err0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wr0;
    send_byte(8'hAA);
    send_byte(8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr0 = wr_cnt;
    send_byte(8'h44);
    tick(3);
    n_checks++;
    if (wr_cnt != wr0 || bus.o_rf_addr !== 4'h0) begin
      n_errors++;
      $display("FAIL rst_abort: writes=%0d addr=%h, want 0/0", wr_cnt - wr0, bus.o_rf_addr);
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int tx0, seen = 0;
    send_byte(8'hAA);
    for (int i = 1; i <= 40 && seen == 0; i++) begin
      tick();
      if (bus.o_cmd_err === 1'b1) seen = i;
    end
    n_checks++;
    if (seen != TO_CYC) begin
      n_errors++; $display("FAIL timeout_err: pulse at cycle %0d, want %0d", seen, TO_CYC);
    end
    tx0 = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h06);
    n_checks++;
    if ({bus.o_rf_rd_en, bus.o_rf_addr} !== {1'b1, 4'h6}) begin
      n_errors++;
      $display("FAIL timeout_rd: en=%b addr=%h, want 1/6", bus.o_rf_rd_en, bus.o_rf_addr);
    end
    tick();
    bus.i_rf_rd_data = 8'h5A; bus.i_rf_rd_valid = 1'b1;
    tick();
    bus.i_rf_rd_valid = 1'b0;
    tick(5);
    n_checks++;
    if (tx_cnt - tx0 != 1 || tx_q.size() == 0 || tx_q[$] !== 8'h5A) begin
      n_errors++; $display("FAIL timeout_tx: got %0d bytes, want 1 byte 5a", tx_cnt - tx0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_addr_mask();
    test_read();
    test_alu_op();
    test_tx_busy();
    test_errors();
    test_reset_mid_frame();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
